singly_linked_list_walker: RTL and testbench

//  Initiator for the singly linked list op/op_start/op_done interface. On a start pulse it

---
 rtl/singly_linked_list_pkg.sv | 39 +++
 rtl/sll_req_handshake.sv | 54 +++++
 rtl/singly_linked_list_walker.sv | 190 +++++++++++++++++++
 tb/tb_singly_linked_list_walker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/singly_linked_list_pkg.sv
// ============================================================================
// Module   : singly_linked_list_pkg
// Brief    : Shared op codes, address helpers and walker state encoding for
//            singly linked list initiators.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package singly_linked_list_pkg;

  // List op encodings on the op/op_start/op_done interface
  localparam logic [2:0] OP_READ         = 3'd0;
  localparam logic [2:0] OP_INSERT_ADDR  = 3'd1;
  localparam logic [2:0] OP_DELETE_VALUE = 3'd2;
  localparam logic [2:0] OP_DELETE_ADDR  = 3'd3;
  localparam logic [2:0] OP_INSERT_INDEX = 3'd5;
  localparam logic [2:0] OP_DELETE_INDEX = 3'd7;

  // Walker states
  typedef enum logic [1:0] {
    WALK_IDLE = 2'd0,
    WALK_REQ  = 2'd1,
    WALK_OUT  = 2'd2,
    WALK_FIN  = 2'd3
  } walk_state_e;

  // Address width must also encode the null address, hence MAX_NODE+1 codes
  function automatic int addr_width(input int max_node);
    return $clog2(max_node + 1);
  endfunction

  // The null address is the first code past the last physical node
  function automatic int addr_null(input int max_node);
    return max_node;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sll_req_handshake.sv
// ============================================================================
// Module   : sll_req_handshake
// Brief    : Hold-until-done op_start generator. A launch pulse raises op_start
//            and latches the address; both stay stable until op_done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sll_req_handshake #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  launch_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  op_done_i,
  output logic                  op_start_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  ack_o
);

  logic                  op_start_q, op_start_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Drop the request on the completion edge so the list never sees a re-trigger
  always_comb begin
    op_start_d = op_start_q;
    addr_d     = addr_q;
    if (op_start_q && op_done_i) begin
      op_start_d = 1'b0;
    end else if (launch_i && !op_start_q) begin
      op_start_d = 1'b1;
      addr_d     = addr_i;
    end
  end

  // Request registers; reset drops op_start immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_start_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      op_start_q <= op_start_d;
      addr_q     <= addr_d;
    end
  end

  assign op_start_o = op_start_q;
  assign addr_o     = addr_q;
  assign ack_o      = op_start_q & op_done_i;

endmodule

`default_nettype wire

// File: rtl/singly_linked_list_walker.sv
// ============================================================================
// Module   : singly_linked_list_walker
// Brief    : Follows a singly linked list from head with read ops and streams
//            each node's payload in list order on a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module singly_linked_list_walker
  import singly_linked_list_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8,
  localparam int ADDR_WIDTH = addr_width(MAX_NODE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  walk_fault_o,
  output logic [ADDR_WIDTH-1:0] node_count_o,
  output logic [2:0]            ll_op_o,
  output logic [ADDR_WIDTH-1:0] ll_addr_o,
  output logic                  ll_op_start_o,
  input  logic                  ll_op_done_i,
  input  logic                  ll_fault_i,
  input  logic [DATA_WIDTH-1:0] ll_data_out_i,
  input  logic [ADDR_WIDTH-1:0] ll_next_node_addr_i,
  input  logic [ADDR_WIDTH-1:0] ll_head_i,
  input  logic [ADDR_WIDTH-1:0] ll_length_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [ADDR_WIDTH-1:0] out_index_o,
  output logic                  out_last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_NULL  = ADDR_WIDTH'(addr_null(MAX_NODE));
  localparam logic [ADDR_WIDTH:0]   ONE_W      = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   MAX_NODE_W = (ADDR_WIDTH+1)'(MAX_NODE);

  walk_state_e           state_q;
  logic                  busy_q, done_q, walk_fault_q, abort_q, cons_fault_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q, next_q, len_q, node_count_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_index_q;
  logic                  out_last_q, out_valid_q;

  logic                  w_ack, w_transfer, w_empty, w_abort, w_guard;
  logic                  w_next_null, w_at_len, w_launch;
  logic [ADDR_WIDTH-1:0] w_launch_addr;

  // Walk decisions shared by the state register and the request generator
  always_comb begin
    w_empty       = (ll_head_i == ADDR_NULL) || (ll_length_i == '0);
    w_transfer    = (state_q == WALK_OUT) && out_valid_q && out_ready_i;
    w_abort       = abort_i || abort_q;
    w_guard       = (({1'b0, out_index_q} + ONE_W) >= MAX_NODE_W);
    w_next_null   = (ll_next_node_addr_i == ADDR_NULL);
    w_at_len      = (({1'b0, node_count_q} + ONE_W) == {1'b0, len_q});
    w_launch      = ((state_q == WALK_IDLE) && start_i && !w_empty) ||
                    (w_transfer && !out_last_q && !w_abort && !w_guard);
    w_launch_addr = (state_q == WALK_IDLE) ? ll_head_i : next_q;
  end

  sll_req_handshake #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_req (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .launch_i   (w_launch),
    .addr_i     (w_launch_addr),
    .op_done_i  (ll_op_done_i),
    .op_start_o (ll_op_start_o),
    .addr_o     (ll_addr_o),
    .ack_o      (w_ack)
  );

  // Walker state machine with registered status and stream outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= WALK_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      walk_fault_q <= 1'b0;
      abort_q      <= 1'b0;
      cons_fault_q <= 1'b0;
      cur_addr_q   <= ADDR_NULL;
      next_q       <= '0;
      len_q        <= '0;
      node_count_q <= '0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WALK_IDLE: begin
          if (start_i) begin
            node_count_q <= '0;
            walk_fault_q <= 1'b0;
            abort_q      <= 1'b0;
            len_q        <= ll_length_i;
            if (w_empty) begin
              state_q <= WALK_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              busy_q     <= 1'b1;
              cur_addr_q <= ll_head_i;
              state_q    <= WALK_REQ;
            end
          end
        end
        WALK_REQ: begin
          // Abort only latches here; the outstanding read must complete
          if (abort_i) abort_q <= 1'b1;
          if (w_ack) begin
            if (ll_fault_i) begin
              walk_fault_q <= 1'b1;
              state_q      <= WALK_FIN;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              out_data_q   <= ll_data_out_i;
              out_addr_q   <= cur_addr_q;
              out_index_q  <= node_count_q;
              next_q       <= ll_next_node_addr_i;
              out_last_q   <= w_next_null || w_at_len;
              cons_fault_q <= w_next_null != w_at_len;
              out_valid_q  <= 1'b1;
              state_q      <= WALK_OUT;
            end
          end
        end
        WALK_OUT: begin
          if (abort_i) abort_q <= 1'b1;
          if (w_transfer) begin
            out_valid_q  <= 1'b0;
            node_count_q <= node_count_q + 1'b1;
            if (out_last_q) begin
              // Chain end and list length must agree, else the list is broken
              walk_fault_q <= cons_fault_q;
              state_q      <= WALK_FIN;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
            end else if (w_abort) begin
              state_q <= WALK_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (w_guard) begin
              // More hops than nodes exist: the chain loops
              walk_fault_q <= 1'b1;
              state_q      <= WALK_FIN;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              cur_addr_q <= next_q;
              state_q    <= WALK_REQ;
            end
          end
        end
        WALK_FIN: begin
          abort_q <= 1'b0;
          state_q <= WALK_IDLE;
        end
        default: state_q <= WALK_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign walk_fault_o = walk_fault_q;
  assign node_count_o = node_count_q;
  assign ll_op_o      = OP_READ;
  assign out_data_o   = out_data_q;
  assign out_addr_o   = out_addr_q;
  assign out_index_o  = out_index_q;
  assign out_last_o   = out_last_q;
  assign out_valid_o  = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_singly_linked_list_walker.sv
// ============================================================================
// Module   : tb_singly_linked_list_walker
// Brief    : Directed bench with a 2-cycle-latency list read model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_singly_linked_list_walker;

  localparam int DW   = 8;
  localparam int MAXN = 8;
  localparam int AW   = 4;
  localparam logic [AW-1:0] NUL = 4'd8;

  logic          clk, rst_n, start, abort, out_ready;
  logic          busy, done, walk_fault, ll_op_start, ll_op_done, ll_fault;
  logic          out_last, out_valid;
  logic [AW-1:0] node_count, ll_addr, ll_next, ll_head, ll_length, out_addr, out_index;
  logic [2:0]    ll_op;
  logic [DW-1:0] ll_data, out_data;

  int checks   = 0;
  int failures = 0;

  singly_linked_list_walker #(.DATA_WIDTH(DW), .MAX_NODE(MAXN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .walk_fault_o(walk_fault), .node_count_o(node_count),
    .ll_op_o(ll_op), .ll_addr_o(ll_addr), .ll_op_start_o(ll_op_start),
    .ll_op_done_i(ll_op_done), .ll_fault_i(ll_fault), .ll_data_out_i(ll_data),
    .ll_next_node_addr_i(ll_next), .ll_head_i(ll_head), .ll_length_i(ll_length),
    .out_data_o(out_data), .out_addr_o(out_addr), .out_index_o(out_index),
    .out_last_o(out_last), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // List storage model: read answers on the cycle after op_start is first seen
  logic [DW-1:0] mem_data [MAXN];
  logic [AW-1:0] mem_next [MAXN];
  logic          mem_fault[MAXN];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ll_op_done <= 1'b0; ll_fault <= 1'b0; ll_data <= '0; ll_next <= '0;
    end else if (ll_op_start && !ll_op_done) begin
      ll_op_done <= 1'b1;
      ll_data    <= (ll_addr < AW'(MAXN)) ? mem_data[ll_addr[2:0]] : '0;
      ll_next    <= (ll_addr < AW'(MAXN)) ? mem_next[ll_addr[2:0]] : NUL;
      ll_fault   <= (ll_addr >= AW'(MAXN)) || mem_fault[ll_addr[2:0]];
    end else begin
      ll_op_done <= 1'b0;
    end
  end

  // Stream ready pattern: mode 0 always ready, mode 1 ready one cycle in three
  int ready_mode = 0;
  int rcnt = 0;
  always @(negedge clk) begin
    rcnt <= rcnt + 1;
    out_ready <= (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
  end

  // Beat recorder and stall-stability monitor
  logic [DW-1:0] beat_data[64];
  logic [AW-1:0] beat_addr[64];
  logic [AW-1:0] beat_idx [64];
  logic          beat_last[64];
  int            beat_n = 0;
  int            stall_err = 0;
  logic          have_prev = 1'b0;
  logic [DW+2*AW:0] prev_pl;
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && beat_n < 64) begin
      beat_data[beat_n] <= out_data;
      beat_addr[beat_n] <= out_addr;
      beat_idx[beat_n]  <= out_index;
      beat_last[beat_n] <= out_last;
      beat_n <= beat_n + 1;
    end
    if (rst_n && have_prev && (!out_valid || {out_data, out_addr, out_index, out_last} != prev_pl))
      stall_err <= stall_err + 1;
    have_prev <= rst_n && out_valid && !out_ready;
    prev_pl   <= {out_data, out_addr, out_index, out_last};
  end

  // op_start pulse-length monitor
  int run = 0;
  int pulses = 0;
  int pulse_err = 0;
  always @(negedge clk) begin
    if (!rst_n) run <= 0;
    else if (ll_op_start) run <= run + 1;
    else begin
      if (run != 0) begin
        pulses <= pulses + 1;
        if (run != 2) pulse_err <= pulse_err + 1;
      end
      run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic start_walk();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk); cyc++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_beat(input int base, input int k, input logic [7:0] d,
                            input logic [3:0] a, input logic last);
    check($sformatf("beat%0d_data", k), {24'd0, beat_data[base+k]}, {24'd0, d});
    check($sformatf("beat%0d_addr", k), {28'd0, beat_addr[base+k]}, {28'd0, a});
    check($sformatf("beat%0d_idx", k),  {28'd0, beat_idx[base+k]},  k);
    check($sformatf("beat%0d_last", k), {31'd0, beat_last[base+k]}, {31'd0, last});
  endtask

  // Three-node list A1@5 -> B2@2 -> C3@7
  task automatic load3();
    for (int i = 0; i < MAXN; i++) begin
      mem_data[i] = 8'h00; mem_next[i] = NUL; mem_fault[i] = 1'b0;
    end
    mem_data[5] = 8'hA1; mem_next[5] = 4'd2;
    mem_data[2] = 8'hB2; mem_next[2] = 4'd7;
    mem_data[7] = 8'hC3; mem_next[7] = NUL;
    ll_head = 4'd5; ll_length = 4'd3;
  endtask

  int cyc, base, p0;
  int ord[8] = '{3, 0, 6, 1, 7, 4, 2, 5};

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    ll_head = NUL; ll_length = '0;
    for (int i = 0; i < MAXN; i++) begin
      mem_data[i] = '0; mem_next[i] = NUL; mem_fault[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_outs", {busy, done, walk_fault, ll_op_start, out_valid, out_last},
          32'd0);
    check("rst_vecs", {node_count, ll_addr, out_addr, out_index, out_data}, 32'd0);
    check("rst_op", {29'd0, ll_op}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty list
    p0 = pulses;
    start_walk();
    check("empty_done_cycle", {30'd0, done, busy}, 32'd2);
    check("empty_count", {28'd0, node_count}, 32'd0);
    check("empty_fault", {31'd0, walk_fault}, 32'd0);
    @(negedge clk);
    check("empty_done_pulse", {31'd0, done}, 32'd0);
    check("empty_no_req", pulses - p0, 0);

    // Three nodes, always ready
    load3();
    base = beat_n; p0 = pulses;
    start_walk();
    check("busy_walk", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    check("walk3_cycles", cyc, 10);
    check("walk3_count", {28'd0, node_count}, 32'd3);
    check("walk3_fault", {31'd0, walk_fault}, 32'd0);
    check("walk3_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("walk3_beats", beat_n - base, 3);
    check_beat(base, 0, 8'hA1, 4'd5, 1'b0);
    check_beat(base, 1, 8'hB2, 4'd2, 1'b0);
    check_beat(base, 2, 8'hC3, 4'd7, 1'b1);
    check("walk3_reqs", pulses - p0, 3);

    // Same list with a stalling consumer
    ready_mode = 1;
    base = beat_n; p0 = pulses;
    start_walk();
    wait_done(cyc);
    check("stall_count", {28'd0, node_count}, 32'd3);
    @(negedge clk);
    check("stall_beats", beat_n - base, 3);
    check_beat(base, 1, 8'hB2, 4'd2, 1'b0);
    check_beat(base, 2, 8'hC3, 4'd7, 1'b1);
    check("stall_payload_stable", stall_err, 0);
    check("stall_reqs", pulses - p0, 3);
    check("req_pulse_len", pulse_err, 0);
    ready_mode = 0;

    // Full list with the chain broken after index 4
    for (int i = 0; i < MAXN; i++) begin
      mem_data[ord[i]] = 8'h10 + 8'(i);
      mem_next[ord[i]] = (i == 7) ? NUL : 4'(ord[(i + 1) % 8]);
      mem_fault[ord[i]] = 1'b0;
    end
    mem_next[ord[4]] = NUL;
    ll_head = 4'd3; ll_length = 4'd8;
    base = beat_n;
    start_walk();
    wait_done(cyc);
    check("broken_fault", {31'd0, walk_fault}, 32'd1);
    check("broken_count", {28'd0, node_count}, 32'd5);
    @(negedge clk);
    check("broken_beats", beat_n - base, 5);
    check_beat(base, 3, 8'h13, 4'd1, 1'b0);
    check_beat(base, 4, 8'h14, 4'd7, 1'b1);
    check("broken_fault_held", {31'd0, walk_fault}, 32'd1);

    // Abort while node 1 is being read
    load3();
    base = beat_n;
    start_walk();
    cyc = 0;
    while (!(ll_op_start && node_count == 4'd1) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check("abort_reach_req1", {31'd0, ll_op_start}, 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_done(cyc);
    check("abort_count", {28'd0, node_count}, 32'd2);
    check("abort_fault", {31'd0, walk_fault}, 32'd0);
    @(negedge clk);
    check("abort_beats", beat_n - base, 2);
    check_beat(base, 1, 8'hB2, 4'd2, 1'b0);

    // List fault on the second read
    mem_fault[2] = 1'b1;
    base = beat_n;
    start_walk();
    wait_done(cyc);
    check("lfault_fault", {31'd0, walk_fault}, 32'd1);
    check("lfault_count", {28'd0, node_count}, 32'd1);
    @(negedge clk);
    check("lfault_beats", beat_n - base, 1);
    mem_fault[2] = 1'b0;

    // Reset in the middle of a request
    start_walk();
    cyc = 0;
    while (!ll_op_start && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check("rst_mid_in_req", {31'd0, ll_op_start}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {busy, done, walk_fault, ll_op_start, out_valid, out_last}, 32'd0);
    check("rst_mid_vecs", {node_count, ll_addr, out_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = beat_n;
    start_walk();
    wait_done(cyc);
    check("post_rst_count", {28'd0, node_count}, 32'd3);
    check("post_rst_fault", {31'd0, walk_fault}, 32'd0);
    @(negedge clk);
    check("post_rst_beats", beat_n - base, 3);
    check_beat(base, 0, 8'hA1, 4'd5, 1'b0);
    check_beat(base, 2, 8'hC3, 4'd7, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
